// File: rtl/gb_irq_ctrl.sv
// Interrupt controller owning IF/IE: detects peripheral requests into IF,
// resolves the highest-priority enabled request and clears it on dispatch.
module gb_irq_ctrl #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [7:0]  LEVEL_MASK    = 8'h00,
  parameter logic [15:0] IF_ADDR       = 16'hFF0F,
  parameter logic [15:0] IE_ADDR       = 16'hFFFF,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_i,
  input  logic               wren,
  output logic [7:0]         data_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               clear_interrupt_flag,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  output logic               irq_pending,
  output logic [15:0]        irq_vector
);

  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] irq_d;

  logic [NUM_IRQ-1:0] lvl;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pick;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [2:0]         idx;
  logic               found;
  logic               wr_if;
  logic               wr_ie;

  assign lvl   = LEVEL_MASK[NUM_IRQ-1:0];
  assign set   = (irq_i & lvl) | (irq_i & ~irq_d & ~lvl);
  assign pend  = if_q & ie_q[NUM_IRQ-1:0];
  assign wr_if = wren && (addr == IF_ADDR);
  assign wr_ie = wren && (addr == IE_ADDR);

  // Lowest pending index wins; pick is its one-hot form for the acknowledge.
  always_comb begin
    idx   = 3'd0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !found) begin
        found   = 1'b1;
        idx     = 3'(i);
        pick[i] = 1'b1;
      end
    end
  end

  assign irq_pending = |pend;
  assign irq_vector  = VECTOR_BASE + 16'(idx) * 16'(VECTOR_STRIDE);
  assign ack_mask    = clear_interrupt_flag ? pick : '0;

  // Unimplemented IF bits read back as 1.
  always_comb begin
    reg_IF              = 8'hFF;
    reg_IF[NUM_IRQ-1:0] = if_q;
  end

  assign reg_IE = ie_q;

  always_comb begin
    data_o = 8'hFF;
    if (addr == IF_ADDR)      data_o = reg_IF;
    else if (addr == IE_ADDR) data_o = reg_IE;
  end

  // irq_d samples through reset so a line held high across reset is not an edge.
  always_ff @(posedge clk) begin
    irq_d <= irq_i;
    if (reset) begin
      if_q <= '0;
      ie_q <= 8'h00;
    end else begin
      if (wr_if) if_q <= data_i[NUM_IRQ-1:0] | set;
      else       if_q <= (if_q & ~ack_mask) | set;
      if (wr_ie) ie_q <= data_i;
    end
  end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Bench for gb_irq_ctrl: a 5-source edge-mode instance and an 8-source
// instance with source 1 level-sensitive, checked against a source-level model.
module tb_gb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data_i;
  logic        wren;
  logic [7:0]  irq;
  logic        clr;

  logic [7:0]  d5_data, d5_if, d5_ie;
  logic        d5_pend;
  logic [15:0] d5_vec;
  logic [7:0]  d8_data, d8_if, d8_ie;
  logic        d8_pend;
  logic [15:0] d8_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gb_irq_ctrl #(.NUM_IRQ(5), .LEVEL_MASK(8'h00)) dut5 (
    .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .wren(wren),
    .data_o(d5_data), .irq_i(irq[4:0]), .clear_interrupt_flag(clr),
    .reg_IF(d5_if), .reg_IE(d5_ie), .irq_pending(d5_pend), .irq_vector(d5_vec)
  );

  gb_irq_ctrl #(.NUM_IRQ(8), .LEVEL_MASK(8'h02)) dut8 (
    .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .wren(wren),
    .data_o(d8_data), .irq_i(irq), .clear_interrupt_flag(clr),
    .reg_IF(d8_if), .reg_IE(d8_ie), .irq_pending(d8_pend), .irq_vector(d8_vec)
  );

  // Model: per-instance flag/enable/previous-line bits, one entry per source.
  int       nsrc [2] = '{5, 8};
  bit [7:0] lvlm [2] = '{8'h00, 8'h02};
  bit [7:0] mf [2];
  bit [7:0] me [2];
  bit [7:0] mp [2];
  bit       started = 0;

  function automatic int lowest_pending(int k);
    for (int i = 0; i < nsrc[k]; i++)
      if (mf[k][i] && me[k][i]) return i;
    return -1;
  endfunction

  function automatic bit [7:0] exp_if(int k);
    bit [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (i >= nsrc[k]) ? 1'b1 : mf[k][i];
    return v;
  endfunction

  function automatic bit [15:0] exp_vec(int k);
    int p = lowest_pending(k);
    return 16'h0040 + 16'((p < 0 ? 0 : p) * 8);
  endfunction

  function automatic bit [7:0] exp_data(int k, bit [15:0] a);
    if (a == 16'hFF0F) return exp_if(k);
    if (a == 16'hFFFF) return me[k];
    return 8'hFF;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  p;
      bit  s [8];
      p = lowest_pending(k);
      for (int i = 0; i < 8; i++)
        s[i] = (i < nsrc[k]) && irq[i] && (lvlm[k][i] || !mp[k][i]);
      if (reset) begin
        mf[k] = 8'h00;
        me[k] = 8'h00;
      end else begin
        for (int i = 0; i < nsrc[k]; i++) begin
          if (wren && addr == 16'hFF0F)
            mf[k][i] = data_i[i] | s[i];
          else
            mf[k][i] = (mf[k][i] && !(clr && i == p)) || s[i];
        end
        if (wren && addr == 16'hFFFF) me[k] = data_i;
      end
      mp[k] = irq;
    end
    if (reset) started = 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("d5_if",   16'(d5_if),   16'(exp_if(0)));
      check("d5_ie",   16'(d5_ie),   16'(me[0]));
      check("d5_pend", 16'(d5_pend), 16'(lowest_pending(0) >= 0));
      check("d5_vec",  d5_vec,       exp_vec(0));
      check("d5_data", 16'(d5_data), 16'(exp_data(0, addr)));
      check("d8_if",   16'(d8_if),   16'(exp_if(1)));
      check("d8_ie",   16'(d8_ie),   16'(me[1]));
      check("d8_pend", 16'(d8_pend), 16'(lowest_pending(1) >= 0));
      check("d8_vec",  d8_vec,       exp_vec(1));
      check("d8_data", 16'(d8_data), 16'(exp_data(1, addr)));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_i = d; wren = 1'b1;
    tick();
    wren = 1'b0; addr = 16'hFF10;
  endtask

  task automatic ack();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 16'hFF10; data_i = 8'h00; wren = 1'b0;
    irq = 8'h04; clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_if5",   16'(d5_if),   16'h00E0);
    check("rst_ie5",   16'(d5_ie),   16'h0000);
    check("rst_pend5", 16'(d5_pend), 16'h0000);
    check("rst_vec5",  d5_vec,       16'h0040);
    check("rst_data5", 16'(d5_data), 16'h00FF);
    check("rst_if8",   16'(d8_if),   16'h0000);
    irq = 8'h00;
    tick();

    bus_wr(16'hFFFF, 8'h1F);
    irq = 8'h04;
    tick();
    check("edge_if_a",  16'(d5_if), 16'h00E4);
    check("edge_vec_a", d5_vec,     16'h0050);
    irq = 8'h01;
    tick();
    check("edge_if_b",  16'(d5_if), 16'h00E5);
    check("edge_vec_b", d5_vec,     16'h0040);
    check("edge_if8",   16'(d8_if), 16'h0005);
    irq = 8'h00;
    tick();

    ack();
    check("ack1_if",  16'(d5_if), 16'h00E4);
    check("ack1_vec", d5_vec,     16'h0050);
    ack();
    check("ack2_if",   16'(d5_if),   16'h00E0);
    check("ack2_pend", 16'(d5_pend), 16'h0000);

    bus_wr(16'hFFFF, 8'h04);
    bus_wr(16'hFF0F, 8'h01);
    check("mask_if",   16'(d5_if),   16'h00E1);
    check("mask_pend", 16'(d5_pend), 16'h0000);
    ack();
    check("mask_ack_if", 16'(d5_if), 16'h00E1);

    irq = 8'h02;
    bus_wr(16'hFF0F, 8'h00);
    check("sim_wr_if5", 16'(d5_if), 16'h00E2);
    check("sim_wr_if8", 16'(d8_if), 16'h0002);
    bus_wr(16'hFFFF, 8'hFF);
    ack();
    check("lvl_ack_if8", 16'(d8_if), 16'h0002);
    check("edge_ack_if5", 16'(d5_if), 16'h00E0);
    irq = 8'h00;
    tick();

    bus_wr(16'hFF0F, 8'h0A);
    bus_wr(16'hFFFF, 8'h3C);
    addr = 16'hFF0F; #1;
    check("rd_if5", 16'(d5_data), 16'h00EA);
    check("rd_if8", 16'(d8_data), 16'h000A);
    addr = 16'hFFFF; #1;
    check("rd_ie5", 16'(d5_data), 16'h003C);
    check("rd_ie8", 16'(d8_data), 16'h003C);
    addr = 16'hFF10; #1;
    check("rd_oth5", 16'(d5_data), 16'h00FF);
    check("rd_oth8", 16'(d8_data), 16'h00FF);
    check("vec5_idx3", d5_vec, 16'h0058);
    check("vec8_idx3", d8_vec, 16'h0058);
    tick();

    bus_wr(16'hFFFF, 8'h80);
    bus_wr(16'hFF0F, 8'h80);
    check("vec8_idx7", d8_vec, 16'h0078);
    check("pend5_none", 16'(d5_pend), 16'h0000);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_if5", 16'(d5_if), 16'h00E0);
    check("mid_rst_if8", 16'(d8_if), 16'h0000);
    check("mid_rst_ie8", 16'(d8_ie), 16'h0000);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
